// File: rtl/sysid_checker_if.sv
// -----------------------------------------------------------------------------
// sysid_checker_if
//   Avalon-MM read link between the system-ID checker (master) and the
//   system-ID slave.
//   m_address     : word select, 0 = system ID, 1 = generation timestamp
//   m_read        : read strobe
//   m_readdata    : read data, valid when m_read=1 and m_waitrequest=0
//   m_waitrequest : slave stall
// -----------------------------------------------------------------------------
interface sysid_checker_if;
  logic        m_address;
  logic        m_read;
  logic [31:0] m_readdata;
  logic        m_waitrequest;

  modport master (
    output m_address,
    output m_read,
    input  m_readdata,
    input  m_waitrequest
  );

  modport slave (
    input  m_address,
    input  m_read,
    output m_readdata,
    output m_waitrequest
  );
endinterface

// File: rtl/sysid_checker.sv
// -----------------------------------------------------------------------------
// sysid_checker
//   Reads word 0 (system ID) and word 1 (generation timestamp) from the
//   system-ID slave and compares both against build-time constants. The boot
//   controller waits on done and blocks on a mismatch or a stuck slave.
//
// Ports
//   clk          : system clock
//   reset_n      : asynchronous active-low reset
//   start_i      : request a (re)check, honoured only in IDLE/DONE
//   bus          : Avalon-MM read master (sysid_checker_if.master)
//   busy_o       : check in progress (RD_ID, RD_TS, CHECK)
//   done_o       : check complete, held until the next start
//   id_ok_o      : captured ID equals EXPECTED_ID
//   ts_ok_o      : captured timestamp equals EXPECTED_TS
//   timeout_o    : a read stalled for TIMEOUT_CYCLES edges
//   read_id_o    : captured ID word
//   read_ts_o    : captured timestamp word
//   irq_o        : sticky mismatch/timeout interrupt (SYSID_CHECKER_IRQ_EN)
//   irq_clear_i  : clears irq_o (SYSID_CHECKER_IRQ_EN)
//
// Build option
//   SYSID_CHECKER_IRQ_EN : when defined, adds irq_o/irq_clear_i and the
//                          interrupt logic; otherwise those ports are absent.
// -----------------------------------------------------------------------------
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'd1768888067,
  parameter logic [31:0] EXPECTED_TS    = 32'd1227733144,
  parameter int unsigned TIMEOUT_CYCLES = 32'd255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start_i,
  sysid_checker_if.master        bus,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   id_ok_o,
  output logic                   ts_ok_o,
  output logic                   timeout_o,
  output logic [31:0]            read_id_o,
  output logic [31:0]            read_ts_o
`ifdef SYSID_CHECKER_IRQ_EN
  ,
  output logic                   irq_o,
  input  logic                   irq_clear_i
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_ID = 3'd1,
    S_RD_TS = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // A zero limit disables the stall watchdog entirely.
  localparam bit          TO_EN       = (TIMEOUT_CYCLES != 32'd0);
  localparam logic [15:0] TO_LAST_CNT = 16'(TIMEOUT_CYCLES - 32'd1);

  state_t      state_q;
  logic        auto_q;
  logic        addr_q;
  logic        read_q;
  logic        busy_q;
  logic        done_q;
  logic        id_ok_q;
  logic        ts_ok_q;
  logic        timeout_q;
  logic [31:0] read_id_q;
  logic [31:0] read_ts_q;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        to_hit_s;
  logic        id_match_s;
  logic        ts_match_s;
`ifdef SYSID_CHECKER_IRQ_EN
  logic        irq_q;
`endif

  // Stall counter increment, watchdog expiry and full-width word compares
  always_comb begin
    cnt_d      = cnt_q + 16'd1;
    to_hit_s   = TO_EN && (cnt_q == TO_LAST_CNT);
    id_match_s = (read_id_q == EXPECTED_ID);
    ts_match_s = (read_ts_q == EXPECTED_TS);
  end

  // Check sequencer: read strobes, word capture, result flags and interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      auto_q    <= AUTO_START;
      addr_q    <= 1'b0;
      read_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      id_ok_q   <= 1'b0;
      ts_ok_q   <= 1'b0;
      timeout_q <= 1'b0;
      read_id_q <= 32'd0;
      read_ts_q <= 32'd0;
      cnt_q     <= 16'd0;
`ifdef SYSID_CHECKER_IRQ_EN
      irq_q     <= 1'b0;
`endif
    end else begin
`ifdef SYSID_CHECKER_IRQ_EN
      // Later set assignments below override this, so set wins over clear.
      if (irq_clear_i) begin
        irq_q <= 1'b0;
      end
`endif
      case (state_q)
        S_IDLE, S_DONE: begin
          // auto_q is only ever set in IDLE straight out of reset.
          if (start_i || auto_q) begin
            state_q   <= S_RD_ID;
            auto_q    <= 1'b0;
            addr_q    <= 1'b0;
            read_q    <= 1'b1;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            id_ok_q   <= 1'b0;
            ts_ok_q   <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= 16'd0;
          end
        end
        S_RD_ID, S_RD_TS: begin
          if (!bus.m_waitrequest) begin
            if (state_q == S_RD_ID) begin
              read_id_q <= bus.m_readdata;
              state_q   <= S_RD_TS;
              addr_q    <= 1'b1;
              cnt_q     <= 16'd0;
            end else begin
              read_ts_q <= bus.m_readdata;
              state_q   <= S_CHECK;
              read_q    <= 1'b0;
            end
          end else if (to_hit_s) begin
            // Abandon the check; the word not yet captured keeps its old value.
            state_q   <= S_DONE;
            read_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            id_ok_q   <= 1'b0;
            ts_ok_q   <= 1'b0;
`ifdef SYSID_CHECKER_IRQ_EN
            irq_q     <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_CHECK: begin
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          id_ok_q <= id_match_s;
          ts_ok_q <= ts_match_s;
`ifdef SYSID_CHECKER_IRQ_EN
          if (!(id_match_s && ts_match_s)) begin
            irq_q <= 1'b1;
          end
`endif
        end
        default: begin
          state_q <= S_IDLE;
          read_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.m_address = addr_q;
  assign bus.m_read    = read_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign id_ok_o       = id_ok_q;
  assign ts_ok_o       = ts_ok_q;
  assign timeout_o     = timeout_q;
  assign read_id_o     = read_id_q;
  assign read_ts_o     = read_ts_q;
`ifdef SYSID_CHECKER_IRQ_EN
  assign irq_o         = irq_q;
`endif

endmodule
